// File: rtl/sub_pipe.sv
// sub_pipe: two-stage valid/ready pipelined signed subtractor, r = a - b at IN_WL+1 bits.
// Revision: 1.0
`default_nettype none

module sub_pipe #(
  parameter int IN_WL  = 15,
  parameter int OUT_WL = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_WL-1:0]  a,
  input  logic [IN_WL-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_WL-1:0] r,
  output logic              r_zero,
  output logic              r_neg
);

  generate
    if (OUT_WL != IN_WL + 1) begin : g_bad_wl
      $error("sub_pipe: OUT_WL must equal IN_WL+1");
    end
  endgenerate

  logic              r_s1_valid;
  logic [OUT_WL-1:0] r_s1_a;
  logic [OUT_WL-1:0] r_s1_nb;
  logic              r_s2_valid;
  logic [OUT_WL-1:0] r_s2_r;
  logic              r_s2_zero;
  logic              r_s2_neg;

  logic              w_s2_en;
  logic              w_s1_en;
  logic [OUT_WL-1:0] w_sum;

  assign w_s2_en  = !r_s2_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  // Two's-complement subtraction: stage 1 holds ~b, the +1 is folded into stage 2.
  assign w_sum = r_s1_a + r_s1_nb + OUT_WL'(1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_nb    <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      r_s1_a     <= {a[IN_WL-1], a};
      r_s1_nb    <= ~{b[IN_WL-1], b};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_s2_valid <= 1'b0;
      r_s2_r     <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_neg   <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_r     <= w_sum;
      r_s2_zero  <= (w_sum == '0);
      r_s2_neg   <= w_sum[OUT_WL-1];
    end
  end

  assign out_valid = r_s2_valid;
  assign r         = r_s2_r;
  assign r_zero    = r_s2_zero;
  assign r_neg     = r_s2_neg;

endmodule

`default_nettype wire

// File: tb/tb_sub_pipe.sv
// tb_sub_pipe: randomized self-checking bench for sub_pipe against an integer-arithmetic queue model.
// Revision: 1.0
`default_nettype none

module tb_sub_pipe;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] a = '0;
  logic [14:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] r;
  logic        r_zero;
  logic        r_neg;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  sub_pipe #(.IN_WL(15), .OUT_WL(16)) dut (
    .clk(clk), .rstb(rstb),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .r_zero(r_zero), .r_neg(r_neg)
  );

  always #5 clk = ~clk;

  function automatic int diff(input logic [14:0] x, input logic [14:0] y);
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx - sy;
  endfunction

  // One clock cycle: drive at negedge, sample just after, record transfers in the model.
  task automatic cycle(input logic iv, input logic [14:0] ia, input logic [14:0] ib,
                       input logic ordy, output logic acc, output logic got,
                       output logic ov, output logic [15:0] rr, output logic z,
                       output logic n, output logic ir);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; out_ready = ordy;
    #1;
    ir  = in_ready;
    ov  = out_valid;
    acc = iv && in_ready;
    got = out_valid && ordy;
    rr  = r; z = r_zero; n = r_neg;
    if (acc) exp_q.push_back(diff(ia, ib));
    @(posedge clk);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #3;
    n_tests++;
    if (out_valid !== 1'b0 || r !== 16'h0 || r_zero !== 1'b0 || r_neg !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b r=%h z=%b n=%b ir=%b, required 0 0000 0 0 1",
               out_valid, r, r_zero, r_neg, in_ready);
    end
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_basic();
    logic acc, got, ov, z, n, ir;
    logic [15:0] rr;
    cycle(1'b1, 15'd100, 15'd250, 1'b1, acc, got, ov, rr, z, n, ir);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: in_ready=%b required 1", ir); end
    cycle(1'b0, 15'd0, 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: out_valid=%b required 0", ov); end
    cycle(1'b0, 15'd0, 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
    n_tests++;
    if (ov !== 1'b1 || rr !== 16'hFF6A || n !== 1'b1 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: ov=%b r=%h z=%b n=%b, required 1 ff6a 0 1", ov, rr, z, n);
    end
    if (got) void'(exp_q.pop_front());
    exp_q.delete();
  endtask

  task automatic test_extremes();
    logic [14:0] va[3] = '{15'h4000, 15'h3FFF, 15'h1234};
    logic [14:0] vb[3] = '{15'h3FFF, 15'h4000, 15'h1234};
    logic [15:0] vr[3] = '{16'h8001, 16'h7FFF, 16'h0000};
    logic        vz[3] = '{1'b0, 1'b0, 1'b1};
    logic        vn[3] = '{1'b1, 1'b0, 1'b0};
    logic acc, got, ov, z, n, ir;
    logic [15:0] rr;
    int k = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(c < 3, (c < 3) ? va[c] : 15'd0, (c < 3) ? vb[c] : 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
      if (got) begin
        n_tests++;
        if (k > 2 || rr !== vr[k] || z !== vz[k] || n !== vn[k]) begin
          n_fail++;
          $display("FAIL extremes_%0d: r=%h z=%b n=%b, required %h %b %b", k, rr, z, n,
                   vr[k % 3], vz[k % 3], vn[k % 3]);
        end
        void'(exp_q.pop_front());
        k++;
      end
    end
    n_tests++;
    if (k != 3) begin n_fail++; $display("FAIL extremes_count: got %0d results, required 3", k); end
  endtask

  task automatic test_throughput();
    logic acc, got, ov, z, n, ir;
    logic [15:0] rr;
    int e;
    int n_acc = 0;
    for (int c = 0; c < 34; c++) begin
      cycle(c < 32, 15'($urandom), 15'($urandom), 1'b1, acc, got, ov, rr, z, n, ir);
      if (acc) n_acc++;
      if (c >= 2) begin
        n_tests++;
        if (!got) begin
          n_fail++;
          $display("FAIL throughput_bubble: cycle %0d out_valid=%b, required 1", c, ov);
        end else begin
          e = exp_q.pop_front();
          if (rr !== 16'(e) || z !== (e == 0) || n !== (e < 0)) begin
            n_fail++;
            $display("FAIL throughput_data: r=%h z=%b n=%b, required %h", rr, z, n, 16'(e));
          end
        end
      end
    end
    n_tests++;
    if (n_acc != 32 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL throughput_count: accepted %0d left %0d, required 32 0", n_acc, exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    logic acc, got, ov, z, n, ir;
    logic [15:0] rr, held;
    logic [14:0] pa, pb;
    int e;
    int n_acc = 0;
    int cyc = 0;
    pa = 15'($urandom); pb = 15'($urandom);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, pa, pb, 1'b0, acc, got, ov, rr, z, n, ir);
      if (acc) begin n_acc++; pa = 15'($urandom); pb = 15'($urandom); end
      if (c == 2) held = rr;
      if (c >= 2) begin
        n_tests++;
        if (ir !== 1'b0 || ov !== 1'b1 || rr !== held) begin
          n_fail++;
          $display("FAIL bp_stall: c=%0d in_ready=%b ov=%b r=%h, required 0 1 %h", c, ir, ov, rr, held);
        end
      end
    end
    n_tests++;
    if (n_acc != 2) begin n_fail++; $display("FAIL bp_accepted: %0d, required 2", n_acc); end
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle(1'b0, 15'd0, 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
      cyc++;
      if (got) begin
        e = exp_q.pop_front();
        n_tests++;
        if (rr !== 16'(e) || z !== (e == 0) || n !== (e < 0)) begin
          n_fail++;
          $display("FAIL bp_drain: r=%h z=%b n=%b, required %h", rr, z, n, 16'(e));
        end
      end
    end
    cycle(1'b0, 15'd0, 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
    n_tests++;
    if (exp_q.size() != 0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_final: left %0d out_valid=%b, required 0 0", exp_q.size(), ov);
    end
  endtask

  task automatic test_random();
    logic acc, got, ov, z, n, ir, iv, ordy;
    logic [15:0] rr;
    logic [14:0] pa, pb;
    logic prev_hold = 1'b0;
    logic [15:0] prev_r = '0;
    int e;
    int n_got = 0;
    int cyc = 0;
    pa = 15'($urandom); pb = 15'($urandom);
    while (n_got < 10000 && cyc < 60000) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(iv, pa, pb, ordy, acc, got, ov, rr, z, n, ir);
      cyc++;
      if (acc) begin pa = 15'($urandom); pb = 15'($urandom); end
      if (prev_hold && (ov !== 1'b1 || rr !== prev_r)) begin
        n_tests++; n_fail++;
        $display("FAIL rand_hold: ov=%b r=%h, required 1 %h", ov, rr, prev_r);
      end
      prev_hold = ov && !ordy;
      prev_r    = rr;
      if (got) begin
        n_got++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: r=%h with empty scoreboard", rr);
        end else begin
          e = exp_q.pop_front();
          if (rr !== 16'(e) || z !== (e == 0) || n !== (e < 0)) begin
            n_fail++;
            $display("FAIL rand_data: r=%h z=%b n=%b, required %h", rr, z, n, 16'(e));
          end
        end
      end
    end
    n_tests++;
    if (n_got < 10000) begin n_fail++; $display("FAIL rand_timeout: %0d results, required 10000", n_got); end
  endtask

  task automatic test_reset_midstream();
    logic acc, got, ov, z, n, ir;
    logic [15:0] rr;
    int e;
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle(1'b0, 15'd0, 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
      cyc++;
      if (got) void'(exp_q.pop_front());
    end
    cycle(1'b1, 15'h0005, 15'h0001, 1'b0, acc, got, ov, rr, z, n, ir);
    cycle(1'b1, 15'h0007, 15'h0002, 1'b0, acc, got, ov, rr, z, n, ir);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_inflight: out_valid=%b required 1", out_valid); end
    #1 rstb = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || r !== 16'h0 || r_zero !== 1'b0 || r_neg !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: ov=%b r=%h z=%b n=%b ir=%b, required 0 0000 0 0 1",
               out_valid, r, r_zero, r_neg, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rstb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 15'd0, 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
      n_tests++;
      if (ov !== 1'b0) begin n_fail++; $display("FAIL rst_stale: out_valid=%b required 0", ov); end
    end
    cycle(1'b1, 15'h7FFF, 15'h0001, 1'b1, acc, got, ov, rr, z, n, ir);
    cyc = 0;
    while (!got && cyc < 5) begin
      cycle(1'b0, 15'd0, 15'd0, 1'b1, acc, got, ov, rr, z, n, ir);
      cyc++;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL rst_recover: no result after release, required one");
    end else begin
      e = exp_q.pop_front();
      if (rr !== 16'(e) || z !== (e == 0) || n !== (e < 0)) begin
        n_fail++;
        $display("FAIL rst_recover: r=%h, required %h", rr, 16'(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_throughput();
    test_back_pressure();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
